// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the sign-magnitude ALU: queues requests, drives one
// ALU transaction at a time and returns the sampled result with its tag.
module alu_cmd_driver #(
    parameter int DEPTH      = 4,
    parameter int RESULT_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [2:0] cmd_op,
    input  logic [4:0] cmd_a,
    input  logic [4:0] cmd_b,
    input  logic [3:0] cmd_tag,
    output logic       alu_en,
    output logic       a_en,
    output logic       b_en,
    output logic [4:0] alu_a,
    output logic [4:0] alu_b,
    output logic [2:0] alu_a_op,
    output logic [1:0] alu_b_op,
    input  logic [5:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [5:0] rsp_c,
    output logic [3:0] rsp_tag,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] txn_count
);

    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW      = AW + 1;
    localparam int LW      = $clog2(RESULT_LAT) + 1;
    localparam int ENTRY_W = 19;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]      count_r, count_nxt_s;
    logic               full_r;
    logic               push_s, pop_s, empty_s;

    logic [1:0] head_mode_s;
    logic [2:0] head_op_s;
    logic [4:0] head_a_s, head_b_s;
    logic [3:0] head_tag_s;

    state_t     state_r, state_nxt_s;
    logic [LW-1:0] lat_cnt_r, lat_cnt_s;
    logic [3:0] cur_tag_r, cur_tag_s;
    logic       wait_done_s;

    logic       alu_en_s, a_en_s, b_en_s;
    logic [4:0] alu_a_s, alu_b_s;
    logic [2:0] alu_a_op_s;
    logic [1:0] alu_b_op_s;
    logic       rsp_valid_s, rsp_err_s;
    logic [5:0] rsp_c_s;
    logic [3:0] rsp_tag_s;
    logic [7:0] txn_count_s;

    // A full FIFO refuses the push even if the FSM pops on the same edge
    assign cmd_ready = !full_r;
    assign empty_s   = (count_r == {CW{1'b0}});
    assign push_s    = cmd_valid && !full_r;
    assign pop_s     = (state_r == IDLE) && !empty_s;
    assign {head_mode_s, head_op_s, head_a_s, head_b_s, head_tag_s} = mem_r[rd_ptr_r];
    assign wait_done_s = (state_r == WAIT) && (lat_cnt_r == LW'(RESULT_LAT - 1));

    // FIFO storage array; flushing is done through the pointers and count
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag};
        end
    end

    // FIFO occupancy after this edge's push/pop
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO pointers, count and registered full flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
        end
    end

    // State register together with every registered output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            lat_cnt_r <= {LW{1'b0}};
            cur_tag_r <= 4'd0;
            alu_en    <= 1'b0;
            a_en      <= 1'b0;
            b_en      <= 1'b0;
            alu_a     <= 5'd0;
            alu_b     <= 5'd0;
            alu_a_op  <= 3'd0;
            alu_b_op  <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_c     <= 6'd0;
            rsp_tag   <= 4'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            txn_count <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            lat_cnt_r <= lat_cnt_s;
            cur_tag_r <= cur_tag_s;
            alu_en    <= alu_en_s;
            a_en      <= a_en_s;
            b_en      <= b_en_s;
            alu_a     <= alu_a_s;
            alu_b     <= alu_b_s;
            alu_a_op  <= alu_a_op_s;
            alu_b_op  <= alu_b_op_s;
            rsp_valid <= rsp_valid_s;
            rsp_c     <= rsp_c_s;
            rsp_tag   <= rsp_tag_s;
            rsp_err   <= rsp_err_s;
            busy      <= (state_nxt_s != IDLE) || (count_nxt_s != {CW{1'b0}});
            txn_count <= txn_count_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_nxt_s = (head_mode_s == 2'b00) ? RESP : LAUNCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH:  state_nxt_s = WAIT;
            WAIT:    state_nxt_s = wait_done_s ? CAPTURE : WAIT;
            CAPTURE: state_nxt_s = rsp_ready ? IDLE : RESP;
            RESP:    state_nxt_s = rsp_ready ? IDLE : RESP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: next values of the ALU-side and response registers
    always_comb begin
        alu_en_s    = 1'b0;
        a_en_s      = a_en;
        b_en_s      = b_en;
        alu_a_s     = alu_a;
        alu_b_s     = alu_b;
        alu_a_op_s  = alu_a_op;
        alu_b_op_s  = alu_b_op;
        rsp_valid_s = rsp_valid;
        rsp_c_s     = rsp_c;
        rsp_tag_s   = rsp_tag;
        rsp_err_s   = rsp_err;
        txn_count_s = txn_count;
        cur_tag_s   = cur_tag_r;
        lat_cnt_s   = lat_cnt_r + LW'(1);
        case (state_r)
            IDLE: begin
                lat_cnt_s = {LW{1'b0}};
                if (pop_s && (head_mode_s == 2'b00)) begin
                    rsp_valid_s = 1'b1;
                    rsp_c_s     = 6'd0;
                    rsp_err_s   = 1'b1;
                    rsp_tag_s   = head_tag_s;
                end else if (pop_s) begin
                    // Counter starts at zero during the alu_en cycle
                    alu_en_s   = 1'b1;
                    alu_a_s    = head_a_s;
                    alu_b_s    = head_b_s;
                    cur_tag_s  = head_tag_s;
                    a_en_s     = (head_mode_s != 2'b10);
                    b_en_s     = (head_mode_s != 2'b01);
                    alu_a_op_s = (head_mode_s == 2'b01) ? head_op_s : 3'd0;
                    alu_b_op_s = (head_mode_s == 2'b01) ? 2'd0 : head_op_s[1:0];
                end else begin
                    alu_en_s = 1'b0;
                end
            end
            LAUNCH: begin
                alu_en_s = 1'b0;
            end
            WAIT: begin
                if (wait_done_s) begin
                    rsp_valid_s = 1'b1;
                    rsp_c_s     = alu_c;
                    rsp_err_s   = 1'b0;
                    rsp_tag_s   = cur_tag_r;
                    a_en_s      = 1'b0;
                    b_en_s      = 1'b0;
                    alu_a_s     = 5'd0;
                    alu_b_s     = 5'd0;
                    alu_a_op_s  = 3'd0;
                    alu_b_op_s  = 2'd0;
                    txn_count_s = txn_count + 8'd1;
                end else begin
                    rsp_valid_s = rsp_valid;
                end
            end
            CAPTURE, RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                rsp_valid_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a behavioural ALU responder that only
// presents a valid C in the cycle before the expected sample edge.
module tb_alu_cmd_driver;

    localparam int RL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'd0;
    logic [2:0] cmd_op = 3'd0;
    logic [4:0] cmd_a = 5'd0, cmd_b = 5'd0;
    logic [3:0] cmd_tag = 4'd0;
    logic       alu_en, a_en, b_en;
    logic [4:0] alu_a, alu_b;
    logic [2:0] alu_a_op;
    logic [1:0] alu_b_op;
    logic [5:0] alu_c;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [5:0] rsp_c;
    logic [3:0] rsp_tag;
    logic       rsp_err;
    logic       busy;
    logic [7:0] txn_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] launch_q[$];
    logic [10:0] rsp_q[$];
    logic [3:0]  k_r = 4'd15;
    logic        en_d_r = 1'b0;
    logic [16:0] cur_r = 17'd0;
    logic [16:0] alu_vec;
    logic [5:0]  model_c;

    always #5 clk = ~clk;

    alu_cmd_driver #(.DEPTH(4), .RESULT_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_tag(cmd_tag), .alu_en(alu_en), .a_en(a_en), .b_en(b_en),
        .alu_a(alu_a), .alu_b(alu_b), .alu_a_op(alu_a_op), .alu_b_op(alu_b_op),
        .alu_c(alu_c), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy),
        .txn_count(txn_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sm(input logic [4:0] v);
        return v[4] ? -int'(v[3:0]) : int'(v[3:0]);
    endfunction

    // Reference ALU behaviour (asymmetric ops so operand swaps are visible)
    function automatic logic [5:0] alu_fn(input logic ae, input logic be, input logic [2:0] aop,
                                          input logic [1:0] bop, input logic [4:0] a, input logic [4:0] b);
        int x, y, r;
        x = sm(a);
        y = sm(b);
        r = 0;
        if (ae && !be) begin
            case (aop)
                3'd0: r = x + y;
                3'd1: r = x - y;
                3'd2: r = y - x;
                3'd3: r = 2 * x;
                default: r = x + 2 * y + int'(aop);
            endcase
        end else if (be && !ae) begin
            case (bop)
                2'd0: r = y;
                2'd1: r = y + 1;
                2'd2: r = -y;
                default: r = 0;
            endcase
        end else if (ae && be) begin
            case (bop)
                2'd0: r = x - 2 * y;
                2'd1: r = y - 1;
                2'd2: r = x + 3;
                default: r = y + 2;
            endcase
        end else begin
            r = 0;
        end
        return 6'(r);
    endfunction

    assign alu_vec = {a_en, b_en, alu_a_op, alu_b_op, alu_a, alu_b};
    assign model_c = alu_fn(a_en, b_en, alu_a_op, alu_b_op, alu_a, alu_b);
    assign alu_c   = (k_r == 4'(RL - 1)) ? model_c : (model_c ^ 6'h15);

    // Monitor: launch/hold/clear checks and in-order response scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            k_r    <= 4'd15;
            en_d_r <= 1'b0;
        end else begin
            en_d_r <= alu_en;
            if (alu_en) begin
                k_r <= 4'd0;
                check_eq("en_while_rsp", {31'd0, rsp_valid}, 32'd0);
                if (en_d_r) check_eq("en_width", {31'd0, en_d_r}, 32'd0);
                if (launch_q.size() == 0) begin
                    check_eq("spurious_en", {31'd0, alu_en}, 32'd0);
                end else begin
                    check_eq("launch", {15'd0, alu_vec}, {15'd0, launch_q[0]});
                    cur_r <= launch_q[0];
                    void'(launch_q.pop_front());
                end
            end else begin
                if (k_r < 4'd15) k_r <= k_r + 4'd1;
                if (k_r < 4'(RL - 1)) check_eq("hold", {15'd0, alu_vec}, {15'd0, cur_r});
            end
            if (rsp_valid) check_eq("clear_after_cap", {15'd0, alu_vec}, 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check_eq("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    check_eq("rsp", {21'd0, rsp_tag, rsp_err, rsp_c}, {21'd0, rsp_q[0]});
                    void'(rsp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [1:0] mode, input logic [2:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [3:0] tag);
        int g;
        logic ae, be;
        logic [2:0] aop;
        logic [1:0] bop;
        g = 0;
        cmd_mode = mode; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) begin
            check_eq("send_timeout", {31'd0, cmd_ready}, 32'd1);
        end else begin
            if (mode == 2'b00) begin
                rsp_q.push_back({tag, 1'b1, 6'd0});
            end else begin
                ae  = (mode != 2'b10);
                be  = (mode != 2'b01);
                aop = (mode == 2'b01) ? op : 3'd0;
                bop = (mode == 2'b01) ? 2'd0 : op[1:0];
                launch_q.push_back({ae, be, aop, bop, a, b});
                rsp_q.push_back({tag, 1'b0, alu_fn(ae, be, aop, bop, a, b)});
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 5'($urandom),
             5'($urandom), 4'($urandom));
    endtask

    task automatic measure_lat(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) break;
        end
        check_eq(tag, n, exp_lat);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((rsp_q.size() != 0 || busy) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 3000) check_eq("drain_timeout", rsp_q.size(), 0);
    endtask

    initial begin
        int g;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_outs", {14'd0, alu_en, rsp_valid, busy, rsp_err, rsp_c, txn_count}, 32'd0);
        check_eq("rst_alu", {15'd0, alu_vec}, 32'd0);

        // A-set add, then B-set2 B+2
        rsp_ready = 1'b1;
        send(2'b01, 3'd0, 5'b00011, 5'b00010, 4'd5);
        measure_lat("lat_aset", 5);
        check_eq("aset_c", {26'd0, rsp_c}, 32'h05);
        drain();
        check_eq("txn_1", {24'd0, txn_count}, 32'd1);
        send(2'b11, 3'd3, 5'd0, 5'b00100, 4'd6);
        drain();
        check_eq("bset2_c", {26'd0, rsp_c}, 32'h06);

        // Illegal mode: immediate error response, no ALU activity
        send(2'b00, 3'd2, 5'd7, 5'd9, 4'd9);
        measure_lat("lat_illegal", 1);
        drain();
        check_eq("txn_illegal", {24'd0, txn_count}, 32'd2);

        // Backpressure: 1 in flight + 4 queued, 6th stalls
        rsp_ready = 1'b0;
        send(2'b01, 3'd1, 5'd6, 5'd2, 4'd1);
        send(2'b10, 3'd3, 5'd1, 5'd5, 4'd2);
        send(2'b10, 3'd1, 5'd3, 5'h13, 4'd3);
        send(2'b11, 3'd0, 5'd4, 5'd1, 4'd4);
        send(2'b01, 3'd2, 5'h12, 5'd3, 4'd7);
        check_eq("full_ready", {31'd0, cmd_ready}, 32'd0);
        fork
            send(2'b11, 3'd2, 5'd2, 5'd0, 4'd8);
            begin
                repeat (6) @(posedge clk);
                #1;
                check_eq("stall_ready", {30'd0, cmd_ready, busy}, 32'd1);
                rsp_ready = 1'b1;
            end
        join
        drain();
        check_eq("txn_bp", {24'd0, txn_count}, 32'd8);

        // Reset two cycles after LAUNCH
        send(2'b01, 3'd0, 5'd1, 5'd1, 4'd12);
        g = 0;
        while (!alu_en && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("wait_en", {31'd0, alu_en}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rsp_q.delete();
        launch_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("mid_rst_outs", {14'd0, alu_en, rsp_valid, busy, rsp_err, rsp_c, txn_count}, 32'd0);
        check_eq("mid_rst_alu", {15'd0, alu_vec}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        send(2'b11, 3'd1, 5'd3, 5'd7, 4'd13);
        drain();
        check_eq("txn_after_rst", {24'd0, txn_count}, 32'd1);

        // Counter wrap
        for (int i = 0; i < 254; i++) send_rand();
        drain();
        check_eq("txn_255", {24'd0, txn_count}, 32'd255);
        send_rand();
        drain();
        check_eq("txn_wrap", {24'd0, txn_count}, 32'd0);
        check_eq("q_empty", launch_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
